dma_manager: RTL and testbench

//  Programs an AXI DMA S2MM channel over AXI-lite whenever the upstream data

---
 rtl/dma_manager_pkg.sv | 52 +++++
 rtl/axi_lite_if.sv | 34 +++
 rtl/dma_manager.sv | 161 ++++++++++++++++
 tb/tb_dma_manager.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_manager_pkg.sv
// ----------------------------------------------------------------------------
// dma_manager_pkg
//   Shared definitions for the DMA S2MM programming sequencer: the DMA
//   control register offsets, the sequencer FSM states, the op-table entry
//   type and a helper that returns the write for a given op index.
// ----------------------------------------------------------------------------
package dma_manager_pkg;

  localparam logic [31:0] DMACR_OFFSET       = 32'h0000_0030;
  localparam logic [31:0] S2MM_DA_OFFSET     = 32'h0000_0048;
  localparam logic [31:0] S2MM_LENGTH_OFFSET = 32'h0000_0058;

  // Index of the final write of one programming sequence
  localparam logic [1:0] LAST_OP = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } op_entry_t;

  // Op table: run bit first, then destination address, then length.
  // Writing the length last is what actually starts the S2MM transfer.
  function automatic op_entry_t opEntry(input logic [1:0]  idx,
                                        input logic [31:0] baseAddr,
                                        input logic [31:0] destAddr,
                                        input logic [31:0] transferLen);
    op_entry_t entry;
    case (idx)
      2'd0: begin
        entry.addr = baseAddr + DMACR_OFFSET;
        entry.data = 32'h0000_0001;
      end
      2'd1: begin
        entry.addr = baseAddr + S2MM_DA_OFFSET;
        entry.data = destAddr;
      end
      default: begin
        entry.addr = baseAddr + S2MM_LENGTH_OFFSET;
        entry.data = transferLen;
      end
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// ----------------------------------------------------------------------------
// axi_lite_if
//   32-bit AXI4-lite bundle without WSTRB/PROT (tied off at integration).
//   master : drives AW/W address+data+valid, BREADY, AR address+valid, RREADY
//   slave  : drives AWREADY, WREADY, BRESP/BVALID, ARREADY, RDATA/RRESP/RVALID
// ----------------------------------------------------------------------------
interface axi_lite_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/dma_manager.sv
// ----------------------------------------------------------------------------
// dma_manager
//   Programs an AXI DMA S2MM channel over AXI-lite each time the acquisition
//   FIFO becomes full: DMACR <= 1, S2MM_DA <= DEST_ADDR,
//   S2MM_LENGTH <= TRANSFER_LEN, issued one write at a time.
// Ports
//   clock      : single rising-edge clock
//   reset      : synchronous, active-high
//   fifo_full  : FIFO full level; its rising edge triggers one sequence
//   axi_lite   : AXI-lite master towards the DMA control slave (write only)
// ----------------------------------------------------------------------------
module dma_manager
  import dma_manager_pkg::*;
#(
  parameter logic [31:0] DMA_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] DEST_ADDR     = 32'h1000_0000,
  parameter logic [31:0] TRANSFER_LEN  = 32'd1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fifo_full,
  axi_lite_if.master axi_lite
);

  state_t      state_q, state_d;
  logic [1:0]  opIdx_q, opIdx_d;
  logic        pending_q, pending_d;
  logic        awDone_q, awDone_d;
  logic        wDone_q, wDone_d;
  logic [31:0] awAddr_q, awAddr_d;
  logic [31:0] wData_q, wData_d;
  logic        awValid_q, awValid_d;
  logic        wValid_q, wValid_d;
  logic        bReady_q, bReady_d;
  logic        fifoFull_q;
  logic        armed_q;
  logic        trigger;
  logic        awHs;
  logic        wHs;
  logic        bHs;
  op_entry_t   curOp;
  logic        unusedInputs;

  // armed_q is low only in the first cycle after reset, so a fifo_full level
  // that is already high when reset releases does not count as an edge.
  assign trigger = fifo_full & ~fifoFull_q & armed_q;
  assign awHs    = awValid_q & axi_lite.AWREADY;
  assign wHs     = wValid_q & axi_lite.WREADY;
  assign bHs     = bReady_q & axi_lite.BVALID;
  assign curOp   = opEntry(opIdx_q, DMA_BASE_ADDR, DEST_ADDR, TRANSFER_LEN);

  assign axi_lite.AWADDR  = awAddr_q;
  assign axi_lite.AWVALID = awValid_q;
  assign axi_lite.WDATA   = wData_q;
  assign axi_lite.WVALID  = wValid_q;
  assign axi_lite.BREADY  = bReady_q;
  assign axi_lite.ARADDR  = 32'h0000_0000;
  assign axi_lite.ARVALID = 1'b0;
  assign axi_lite.RREADY  = 1'b0;

  // Error responses and the read channel are deliberately not consumed
  assign unusedInputs = ^{axi_lite.BRESP, axi_lite.ARREADY, axi_lite.RDATA,
                          axi_lite.RRESP, axi_lite.RVALID};

  // State and registered AXI outputs; reset aborts any sequence in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      opIdx_q    <= 2'd0;
      pending_q  <= 1'b0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      awAddr_q   <= 32'h0000_0000;
      wData_q    <= 32'h0000_0000;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      bReady_q   <= 1'b0;
      fifoFull_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      opIdx_q    <= opIdx_d;
      pending_q  <= pending_d;
      awDone_q   <= awDone_d;
      wDone_q    <= wDone_d;
      awAddr_q   <= awAddr_d;
      wData_q    <= wData_d;
      awValid_q  <= awValid_d;
      wValid_q   <= wValid_d;
      bReady_q   <= bReady_d;
      fifoFull_q <= fifo_full;
      armed_q    <= 1'b1;
    end
  end

  // Sequencer: one AW/W/B transaction per op, AW and W handshakes tracked
  // independently so either channel may complete first.
  always_comb begin
    state_d   = state_q;
    opIdx_d   = opIdx_q;
    pending_d = pending_q;
    awDone_d  = awDone_q;
    wDone_d   = wDone_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    awValid_d = awValid_q;
    wValid_d  = wValid_q;
    bReady_d  = bReady_q;

    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          pending_d = 1'b0;
          opIdx_d   = 2'd0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        awAddr_d  = curOp.addr;
        wData_d   = curOp.data;
        awValid_d = 1'b1;
        wValid_d  = 1'b1;
        awDone_d  = 1'b0;
        wDone_d   = 1'b0;
        state_d   = WRITE;
      end
      WRITE: begin
        if (awHs) begin
          awValid_d = 1'b0;
          awDone_d  = 1'b1;
        end
        if (wHs) begin
          wValid_d = 1'b0;
          wDone_d  = 1'b1;
        end
        if ((awDone_q || awHs) && (wDone_q || wHs)) begin
          bReady_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bHs) begin
          bReady_d = 1'b0;
          if (opIdx_q == LAST_OP) begin
            state_d = IDLE;
          end else begin
            opIdx_d = opIdx_q + 2'd1;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Triggers arriving while busy collapse into a single queued sequence
    if (trigger && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_manager.sv
// ----------------------------------------------------------------------------
// tb_dma_manager
//   Directed bench for dma_manager with a behavioural AXI-lite slave that has
//   programmable AWREADY/WREADY delays and an optional SLVERR response.
//   Expected writes are queued when a trigger is driven and popped when the
//   slave sees the corresponding write complete.
// ----------------------------------------------------------------------------
module tb_dma_manager;

  localparam logic [31:0] BASE = 32'h4040_0000;
  localparam logic [31:0] DEST = 32'h1000_0000;
  localparam logic [31:0] LEN  = 32'd1024;

  logic clock = 1'b0;
  logic reset;
  logic fifo_full;

  axi_lite_if axi ();

  dma_manager #(
    .DMA_BASE_ADDR(BASE),
    .DEST_ADDR    (DEST),
    .TRANSFER_LEN (LEN)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fifo_full(fifo_full),
    .axi_lite (axi)
  );

  always #5 clock = ~clock;

  logic [63:0] sbq[$];
  logic [31:0] mem [logic [31:0]];
  int          compared   = 0;
  int          mismatched = 0;
  int          cycle      = 0;
  int          writeCount = 0;
  int          edgeCycle  = 0;
  int          awRise[$];
  logic        awValidPrev = 1'b0;

  int          awDelay = 0;
  int          wDelay  = 0;
  logic        slvErrNext = 1'b0;
  int          awWait  = 0;
  int          wWait   = 0;
  int          awState = 0;
  int          wState  = 0;
  logic        bHsPending = 1'b0;
  logic [31:0] awFirst, wFirst, capAddr, capData;

  // Posedge counter used for latency measurements
  always @(posedge clock) cycle <= cycle + 1;

  // Records the cycle of every AWVALID rising edge
  initial begin
    forever begin
      @(negedge clock);
      if (axi.AWVALID === 1'b1 && awValidPrev !== 1'b1) awRise.push_back(cycle);
      awValidPrev = axi.AWVALID;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushSequence();
    sbq.push_back({BASE + 32'h30, 32'h0000_0001});
    sbq.push_back({BASE + 32'h48, DEST});
    sbq.push_back({BASE + 32'h58, LEN});
  endtask

  // Raise fifo_full on the next negedge, hold it, then drop it again
  task automatic applyStimulus(input int holdCycles, input bit expectSeq);
    @(negedge clock);
    fifo_full = 1'b1;
    edgeCycle = cycle;
    if (expectSeq) pushSequence();
    repeat (holdCycles) @(negedge clock);
    fifo_full = 1'b0;
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n = 0;
    while (writeCount < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wait_writes", 64'(writeCount >= target), 64'h1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || axi.BVALID || axi.BREADY || axi.AWVALID || axi.WVALID)
           && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (10) @(negedge clock);
    checkOutput("drain_pending", 64'(sbq.size()), 64'h0);
  endtask

  // One negedge step of the AXI-lite slave: retire B, finish AW/W, raise B,
  // then accept new AW/W after the configured delays.
  task automatic slaveStep();
    logic [63:0] exp;
    if (reset) begin
      axi.AWREADY = 1'b0;
      axi.WREADY  = 1'b0;
      axi.BVALID  = 1'b0;
      axi.BRESP   = 2'b00;
      awState = 0; wState = 0; awWait = 0; wWait = 0; bHsPending = 1'b0;
    end else begin
      if (bHsPending) begin
        axi.BVALID = 1'b0;
        axi.BRESP  = 2'b00;
        bHsPending = 1'b0;
        awState = 0;
        wState  = 0;
      end
      if (awState == 1) begin
        axi.AWREADY = 1'b0;
        awState = 2;
        checkOutput("awvalid_drop", 64'(axi.AWVALID), 64'h0);
      end
      if (wState == 1) begin
        axi.WREADY = 1'b0;
        wState = 2;
        checkOutput("wvalid_drop", 64'(axi.WVALID), 64'h0);
      end
      if (awState == 2 && wState == 2 && !axi.BVALID) begin
        axi.BVALID = 1'b1;
        axi.BRESP  = slvErrNext ? 2'b10 : 2'b00;
        slvErrNext = 1'b0;
        mem[capAddr] = capData;
        writeCount++;
        if (sbq.size() == 0) begin
          checkOutput("unexpected_write", {capAddr, capData}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp = sbq.pop_front();
          checkOutput("write", {capAddr, capData}, exp);
        end
      end
      if (axi.BVALID && axi.BREADY) bHsPending = 1'b1;
      if (awState == 0) begin
        if (awWait > 0) checkOutput("aw_stable", {31'b0, axi.AWVALID, axi.AWADDR}, {32'h1, awFirst});
        if (axi.AWVALID || awWait > 0) begin
          if (awWait == 0) awFirst = axi.AWADDR;
          if (awWait >= awDelay) begin
            axi.AWREADY = 1'b1;
            awState = 1;
            capAddr = awFirst;
            awWait  = 0;
          end else begin
            awWait++;
          end
        end
      end
      if (wState == 0) begin
        if (wWait > 0) checkOutput("w_stable", {31'b0, axi.WVALID, axi.WDATA}, {32'h1, wFirst});
        if (axi.WVALID || wWait > 0) begin
          if (wWait == 0) wFirst = axi.WDATA;
          if (wWait >= wDelay) begin
            axi.WREADY = 1'b1;
            wState  = 1;
            capData = wFirst;
            wWait   = 0;
          end else begin
            wWait++;
          end
        end
      end
    end
  endtask

  initial begin
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.ARREADY = 1'b0;
    axi.RDATA   = 32'h0;
    axi.RRESP   = 2'b00;
    axi.RVALID  = 1'b0;
    forever begin
      @(negedge clock);
      slaveStep();
    end
  end

  initial begin
    int start;
    int n;

    reset = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_valids", {59'b0, axi.AWVALID, axi.WVALID, axi.BREADY,
                                 axi.ARVALID, axi.RREADY}, 64'h0);
    checkOutput("reset_addr_data", {axi.AWADDR, axi.WDATA}, 64'h0);
    checkOutput("reset_araddr", 64'(axi.ARADDR), 64'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("idle_no_writes", 64'(writeCount), 64'h0);

    $display("[TB] single trigger, always-ready slave");
    mem.delete();
    awRise.delete();
    start = writeCount;
    applyStimulus(4, 1'b1);
    waitDrain(100);
    checkOutput("t1_count", 64'(writeCount - start), 64'd3);
    checkOutput("t1_latency", 64'(awRise[0] - edgeCycle), 64'd2);
    checkOutput("t1_mem_dmacr", 64'(mem[BASE + 32'h30]), 64'h1);
    checkOutput("t1_mem_da", 64'(mem[BASE + 32'h48]), 64'(DEST));
    checkOutput("t1_mem_len", 64'(mem[BASE + 32'h58]), 64'(LEN));
    checkOutput("t1_read_idle", {62'b0, axi.ARVALID, axi.RREADY}, 64'h0);

    $display("[TB] backpressure AW=3 W=5");
    awDelay = 3;
    wDelay  = 5;
    start = writeCount;
    applyStimulus(2, 1'b1);
    waitDrain(200);
    checkOutput("t2_count", 64'(writeCount - start), 64'd3);

    $display("[TB] trigger while busy");
    awDelay = 0;
    wDelay  = 0;
    awRise.delete();
    start = writeCount;
    applyStimulus(2, 1'b1);
    waitWrites(start + 1, 50);
    applyStimulus(2, 1'b1);
    waitDrain(200);
    checkOutput("t3_count", 64'(writeCount - start), 64'd6);
    checkOutput("t3_restart_gap", 64'(awRise[3] - awRise[2]), 64'd4);

    $display("[TB] two triggers while busy merge");
    start = writeCount;
    applyStimulus(2, 1'b1);
    waitWrites(start + 1, 50);
    applyStimulus(1, 1'b1);
    applyStimulus(1, 1'b0);
    waitDrain(200);
    checkOutput("t3b_count", 64'(writeCount - start), 64'd6);

    $display("[TB] fifo_full high across reset release");
    @(negedge clock);
    reset = 1'b1;
    fifo_full = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    awRise.delete();
    start = writeCount;
    repeat (20) @(negedge clock);
    checkOutput("t4_no_writes", 64'(writeCount - start), 64'd0);
    checkOutput("t4_no_awvalid", 64'(awRise.size()), 64'd0);
    fifo_full = 1'b0;
    applyStimulus(3, 1'b1);
    waitDrain(100);
    checkOutput("t4_count", 64'(writeCount - start), 64'd3);

    $display("[TB] reset during write 2");
    awDelay = 2;
    wDelay  = 2;
    start = writeCount;
    applyStimulus(2, 1'b1);
    waitWrites(start + 1, 60);
    n = 0;
    while (axi.AWVALID !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("t5_write2_started", 64'(axi.AWVALID), 64'h1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t5_valids_cleared", {59'b0, axi.AWVALID, axi.WVALID, axi.BREADY,
                                      axi.ARVALID, axi.RREADY}, 64'h0);
    checkOutput("t5_addr_cleared", {axi.AWADDR, axi.WDATA}, 64'h0);
    checkOutput("t5_aborted_left", 64'(sbq.size()), 64'd2);
    sbq.delete();
    @(negedge clock);
    reset = 1'b0;
    awDelay = 0;
    wDelay  = 0;
    repeat (3) @(negedge clock);
    checkOutput("t5_partial_count", 64'(writeCount - start), 64'd1);
    applyStimulus(2, 1'b1);
    waitDrain(100);
    checkOutput("t5_count", 64'(writeCount - start), 64'd4);

    $display("[TB] SLVERR on write 1");
    mem.delete();
    slvErrNext = 1'b1;
    start = writeCount;
    applyStimulus(2, 1'b1);
    waitDrain(100);
    checkOutput("t6_count", 64'(writeCount - start), 64'd3);
    checkOutput("t6_mem_len", 64'(mem[BASE + 32'h58]), 64'(LEN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net in case a wait above never returns
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
